prbs_gen_check: RTL and testbench

//  Parametrised PRBS engine: Fibonacci LFSR generator with runtime-programmable tap mask,

---
 rtl/prbs_gen_check_pkg.sv | 44 ++++
 rtl/prbs_gen_check_lfsr_leap.sv | 30 +++
 rtl/prbs_gen_check.sv | 196 +++++++++++++++++++
 tb/tb_prbs_gen_check.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_gen_check_pkg.sv
`default_nettype none
// ============================================================================
// Package  : prbs_pkg
// Brief    : Shared constants and helpers for the PRBS generator/checker:
//            default tap masks per common width, checker state encoding and
//            a popcount helper for the error counter.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  // Maximal-length tap masks (bit k set = tap k+1)
  localparam logic [7:0]  POLY_W8  = 8'hB8;                  // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] POLY_W16 = 16'hB400;               // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] POLY_W32 = 32'h8020_0003;          // x^32+x^22+x^2+x^1+1
  localparam logic [63:0] POLY_W64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  // Checker lock state
  typedef enum logic [0:0] {
    CHK_HUNT   = 1'b0,
    CHK_LOCKED = 1'b1
  } chk_state_e;

  // Default tap mask for a register width; unknown widths fall back to 32
  function automatic logic [63:0] default_poly(input int width);
    case (width)
      8:       return 64'(POLY_W8);
      16:      return 64'(POLY_W16);
      64:      return POLY_W64;
      default: return 64'(POLY_W32);
    endcase
  endfunction

  // Number of set bits in a vector of up to 64 bits
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_gen_check_lfsr_leap.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_leap
// Brief    : Combinational leap-ahead of a Fibonacci LFSR by STEP single
//            steps. Each step shifts left and inserts the XOR of the tapped
//            bits at bit 0, so the newest bit lands in bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_leap #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic [WIDTH-1:0] state_in,
  input  logic [WIDTH-1:0] poly,
  output logic [WIDTH-1:0] state_out
);

  logic [WIDTH-1:0] r;

  // Unroll STEP single-bit LFSR steps
  always_comb begin
    r = state_in;
    for (int i = 0; i < STEP; i++) begin
      r = {r[WIDTH-2:0], ^(r & poly)};
    end
    state_out = r;
  end

endmodule
`default_nettype wire

// File: rtl/prbs_gen_check.sv
`default_nettype none
// ============================================================================
// Module   : prbs_gen_check
// Brief    : PRBS generator (programmable taps, STEP bits/beat, seed load,
//            save/restore) and self-synchronising checker with lock
//            detection and a saturating bit-error counter.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_gen_check
  import prbs_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          STEP       = 8,
  parameter logic [63:0] POLY       = default_poly(32),
  parameter logic [63:0] SEED       = 64'd1,
  parameter int          LOCK_BEATS = 4,
  parameter int          LOSS_BEATS = 4,
  parameter int          ERRCNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                poly_wr,
  input  logic [WIDTH-1:0]    poly_in,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic                save,
  input  logic                restore,
  output logic [WIDTH-1:0]    gen_q,
  output logic [STEP-1:0]     gen_bits,
  output logic                gen_valid,
  input  logic                chk_valid,
  input  logic [STEP-1:0]     chk_bits,
  input  logic                chk_clr,
  output logic                chk_locked,
  output logic                chk_err,
  output logic [ERRCNT_W-1:0] chk_errcnt
);

  localparam logic [WIDTH-1:0]    MSB_MASK   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]    SEED_W     = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]    SEED_RST   = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [WIDTH-1:0]    POLY_RST   = WIDTH'(POLY) | MSB_MASK;
  localparam int                  FILL_BEATS = (WIDTH + STEP - 1) / STEP;
  localparam int                  FILL_W     = $clog2(FILL_BEATS + 1);
  localparam int                  RUN_MAX    = (LOCK_BEATS > LOSS_BEATS) ? LOCK_BEATS : LOSS_BEATS;
  localparam int                  RUN_W      = $clog2(RUN_MAX + 1);
  localparam int                  SUM_W      = ERRCNT_W + 8;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

  // Generator state
  logic [WIDTH-1:0] gen_d, save_q, save_d, poly_q, poly_d, gen_leap;
  logic             gen_valid_q, gen_valid_d;

  // Checker state
  chk_state_e          state_q, state_d;
  logic [WIDTH-1:0]    c_q, c_d, c_shift, chk_leap;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [RUN_W-1:0]    run_q, run_d, run_inc;
  logic                chk_err_q, chk_err_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d, errcnt_sat;
  logic [STEP-1:0]     mism;
  logic [6:0]          mism_cnt;
  logic [SUM_W-1:0]    errcnt_sum;

  lfsr_leap #(.WIDTH(WIDTH), .STEP(STEP)) u_gen_leap (
    .state_in  (gen_q),
    .poly      (poly_q),
    .state_out (gen_leap)
  );

  lfsr_leap #(.WIDTH(WIDTH), .STEP(STEP)) u_chk_leap (
    .state_in  (c_q),
    .poly      (poly_q),
    .state_out (chk_leap)
  );

  // Received bits shifted into the checker register while hunting
  generate
    if (STEP < WIDTH) begin : g_shift_part
      assign c_shift = {c_q[WIDTH-STEP-1:0], chk_bits};
    end else begin : g_shift_full
      assign c_shift = chk_bits;
    end
  endgenerate

  assign mism       = chk_leap[STEP-1:0] ^ chk_bits;
  assign mism_cnt   = popcount(64'(mism));
  assign errcnt_sum = SUM_W'(errcnt_q) + SUM_W'(mism_cnt);
  assign errcnt_sat = (errcnt_sum > SUM_W'(ERRCNT_MAX)) ? ERRCNT_MAX : errcnt_sum[ERRCNT_W-1:0];
  assign run_inc    = run_q + RUN_W'(1);

  // Generator next state: seed_load beats restore beats enable; never all-zero
  always_comb begin
    gen_d       = gen_q;
    gen_valid_d = 1'b0;
    save_d      = save ? gen_q : save_q;
    poly_d      = poly_wr ? (poly_in | MSB_MASK) : poly_q;
    if (seed_load) begin
      gen_d = (seed_in == '0) ? WIDTH'(1) : seed_in;
    end else if (restore) begin
      gen_d = (save_q == '0) ? WIDTH'(1) : save_q;
    end else if (enable) begin
      gen_d       = gen_leap;
      gen_valid_d = 1'b1;
    end
  end

  // Generator registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_q       <= SEED_RST;
      save_q      <= SEED_RST;
      poly_q      <= POLY_RST;
      gen_valid_q <= 1'b0;
    end else begin
      gen_q       <= gen_d;
      save_q      <= save_d;
      poly_q      <= poly_d;
      gen_valid_q <= gen_valid_d;
    end
  end

  // Checker next state: hunt by shifting in received bits, free-run once locked
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    fill_d    = fill_q;
    run_d     = run_q;
    chk_err_d = 1'b0;
    errcnt_d  = errcnt_q;
    if (poly_wr && (state_q == CHK_LOCKED)) begin
      // New taps invalidate the free-running prediction
      state_d = CHK_HUNT;
      fill_d  = '0;
      run_d   = '0;
    end else if (chk_valid) begin
      if (state_q == CHK_HUNT) begin
        c_d = c_shift;
        if (fill_q != FILL_W'(FILL_BEATS)) begin
          fill_d = fill_q + FILL_W'(1);
        end else if (mism != '0) begin
          run_d = '0;
        end else if (run_inc == RUN_W'(LOCK_BEATS)) begin
          state_d = CHK_LOCKED;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end else begin
        c_d       = chk_leap;
        chk_err_d = |mism;
        errcnt_d  = errcnt_sat;
        if (mism == '0) begin
          run_d = '0;
        end else if (run_inc == RUN_W'(LOSS_BEATS)) begin
          state_d = CHK_HUNT;
          fill_d  = '0;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end
    end
    if (chk_clr) begin
      errcnt_d = '0;
    end
  end

  // Checker registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CHK_HUNT;
      c_q       <= '0;
      fill_q    <= '0;
      run_q     <= '0;
      chk_err_q <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      chk_err_q <= chk_err_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign gen_bits   = gen_q[STEP-1:0];
  assign gen_valid  = gen_valid_q;
  assign chk_locked = (state_q == CHK_LOCKED);
  assign chk_err    = chk_err_q;
  assign chk_errcnt = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_gen_check
// Brief    : Directed self-checking bench for prbs_gen_check: an 8-bit
//            single-step generator for the period check and a 32-bit,
//            8-bit-per-beat instance in gen->chk loopback with bit flips.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_gen_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable, poly_wr, seed_load, save, restore, chk_clr;
  logic [31:0] poly_in, seed_in, gen_q;
  logic [7:0]  gen_bits, flip, chk_bits;
  logic        gen_valid, chk_locked, chk_err;
  logic [3:0]  chk_errcnt;

  logic        enable8;
  logic [7:0]  gen_q8;
  logic [0:0]  gen_bits8;
  logic        gen_valid8, chk_locked8, chk_err8;
  logic [15:0] chk_errcnt8;

  int          n_vec = 0;
  int          n_miss = 0;
  int          bad;
  logic [31:0] m [0:105];

  assign chk_bits = gen_bits ^ flip;

  prbs_gen_check #(
    .WIDTH(32), .STEP(8), .POLY(64'h8020_0003), .SEED(64'd1),
    .LOCK_BEATS(4), .LOSS_BEATS(4), .ERRCNT_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .poly_wr(poly_wr), .poly_in(poly_in),
    .seed_load(seed_load), .seed_in(seed_in),
    .save(save), .restore(restore),
    .gen_q(gen_q), .gen_bits(gen_bits), .gen_valid(gen_valid),
    .chk_valid(gen_valid), .chk_bits(chk_bits), .chk_clr(chk_clr),
    .chk_locked(chk_locked), .chk_err(chk_err), .chk_errcnt(chk_errcnt)
  );

  prbs_gen_check #(
    .WIDTH(8), .STEP(1), .POLY(64'hB8), .SEED(64'd1),
    .LOCK_BEATS(4), .LOSS_BEATS(4), .ERRCNT_W(16)
  ) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable8),
    .poly_wr(1'b0), .poly_in(8'h00),
    .seed_load(1'b0), .seed_in(8'h00),
    .save(1'b0), .restore(1'b0),
    .gen_q(gen_q8), .gen_bits(gen_bits8), .gen_valid(gen_valid8),
    .chk_valid(1'b0), .chk_bits(1'b0), .chk_clr(1'b0),
    .chk_locked(chk_locked8), .chk_err(chk_err8), .chk_errcnt(chk_errcnt8)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference leap: 8 Fibonacci steps with taps x^32+x^22+x^2+x^1+1
  function automatic logic [31:0] ref_leap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[30:0], ^(r & 32'h8020_0003)};
    return r;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; enable8 = 1'b0; poly_wr = 1'b0; seed_load = 1'b0;
    save = 1'b0; restore = 1'b0; chk_clr = 1'b0; poly_in = '0; seed_in = '0; flip = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_vec("rst_gen_q", gen_q, 32'h1);
    check_vec("rst_gen_bits", gen_bits, 8'h01);
    check_vec("rst_gen_valid", gen_valid, 1'b0);
    check_vec("rst_locked", chk_locked, 1'b0);
    check_vec("rst_err", chk_err, 1'b0);
    check_vec("rst_errcnt", chk_errcnt, 4'h0);
    check_vec("rst_gen_q8", gen_q8, 8'h01);

    // 8-bit maximal-length period: 1,2,4,8,11,23,47,... back to 1 at 255
    enable8 = 1'b1;
    bad = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k == 4) check_vec("p8_step4", gen_q8, 8'h11);
      if (k == 6) check_vec("p8_step6", gen_q8, 8'h47);
      if (k < 255 && (gen_q8 == 8'h00 || gen_q8 == 8'h01)) bad++;
    end
    check_vec("p8_period", gen_q8, 8'h01);
    check_vec("p8_early_repeat", bad, 0);
    enable8 = 1'b0;

    // Hand-computed beats from seed 1, then lock after 4 fill + 4 clean beats
    enable = 1'b1;
    tick();
    check_vec("beat1_gen_q", gen_q, 32'h0000_01B6);
    check_vec("beat1_gen_bits", gen_bits, 8'hB6);
    check_vec("beat1_gen_valid", gen_valid, 1'b1);
    tick();
    check_vec("beat2_gen_q", gen_q, 32'h0001_B6DB);
    repeat (6) tick();
    check_vec("lock_not_yet", chk_locked, 1'b0);
    tick();
    check_vec("lock_rise", chk_locked, 1'b1);

    // Long clean loopback
    bad = 0;
    repeat (10000) begin
      tick();
      if (!chk_locked || chk_err) bad++;
    end
    check_vec("clean_bad_beats", bad, 0);
    check_vec("clean_errcnt", chk_errcnt, 4'h0);

    // Single-bit then three-bit error while locked
    flip = 8'h08;
    tick();
    flip = 8'h00;
    check_vec("err1_pulse", chk_err, 1'b1);
    check_vec("err1_cnt", chk_errcnt, 4'd1);
    check_vec("err1_locked", chk_locked, 1'b1);
    flip = 8'h07;
    tick();
    flip = 8'h00;
    check_vec("err3_cnt", chk_errcnt, 4'd4);
    tick();
    check_vec("err_pulse_end", chk_err, 1'b0);
    check_vec("err_locked_held", chk_locked, 1'b1);

    // Four corrupted beats: counter saturates, lock lost on the fourth
    flip = 8'hFF;
    tick();
    check_vec("corrupt1_cnt", chk_errcnt, 4'd12);
    tick();
    check_vec("corrupt2_sat", chk_errcnt, 4'd15);
    tick();
    check_vec("corrupt3_locked", chk_locked, 1'b1);
    tick();
    check_vec("corrupt4_unlock", chk_locked, 1'b0);
    check_vec("corrupt4_sat", chk_errcnt, 4'd15);
    flip = 8'h00;
    repeat (7) tick();
    check_vec("relock_not_yet", chk_locked, 1'b0);
    tick();
    check_vec("relock", chk_locked, 1'b1);
    check_vec("relock_cnt_held", chk_errcnt, 4'd15);

    // chk_clr wins over a same-cycle increment
    chk_clr = 1'b1;
    flip = 8'h01;
    tick();
    chk_clr = 1'b0;
    flip = 8'h00;
    check_vec("clr_cnt", chk_errcnt, 4'd0);
    check_vec("clr_err_pulse", chk_err, 1'b1);
    tick();
    check_vec("clr_cnt_after", chk_errcnt, 4'd0);

    // poly_wr while locked forces HUNT, then relock on clean stream
    poly_in = 32'h8020_0003;
    poly_wr = 1'b1;
    tick();
    poly_wr = 1'b0;
    check_vec("polywr_unlock", chk_locked, 1'b0);
    repeat (7) tick();
    check_vec("polywr_relock_not_yet", chk_locked, 1'b0);
    tick();
    check_vec("polywr_relock", chk_locked, 1'b1);

    // Save at beat 5, run 100 beats, restore, replay 100 beats
    enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m[0] = 32'h1;
    for (int k = 1; k <= 105; k++) m[k] = ref_leap(m[k-1]);
    enable = 1'b1;
    repeat (5) tick();
    check_vec("save_point", gen_q, m[5]);
    save = 1'b1;
    tick();
    save = 1'b0;
    check_vec("run1_bits", gen_bits, m[6][7:0]);
    for (int k = 7; k <= 105; k++) begin
      tick();
      check_vec("run1_bits", gen_bits, m[k][7:0]);
    end
    restore = 1'b1;
    tick();
    restore = 1'b0;
    check_vec("restore_gen_q", gen_q, m[5]);
    check_vec("restore_no_valid", gen_valid, 1'b0);
    for (int k = 6; k <= 105; k++) begin
      tick();
      check_vec("replay_bits", gen_bits, m[k][7:0]);
    end
    check_vec("replay_end", gen_q, m[105]);

    // Seed load, zero seed, swap, priority
    enable = 1'b0;
    seed_load = 1'b1;
    seed_in = 32'h0;
    tick();
    check_vec("seed_zero", gen_q, 32'h1);
    seed_in = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    check_vec("seed_load", gen_q, 32'hDEAD_BEEF);
    save = 1'b1;
    restore = 1'b1;
    tick();
    save = 1'b0;
    check_vec("swap_gen_q", gen_q, m[5]);
    tick();
    restore = 1'b0;
    check_vec("swap_slot", gen_q, 32'hDEAD_BEEF);
    enable = 1'b1;
    seed_load = 1'b1;
    seed_in = 32'h1234_5678;
    tick();
    check_vec("seed_over_enable", gen_q, 32'h1234_5678);
    check_vec("seed_no_valid", gen_valid, 1'b0);

    // New tap mask (only the forced MSB tap) takes effect the next cycle
    enable = 1'b0;
    seed_in = 32'h1;
    tick();
    seed_load = 1'b0;
    poly_in = 32'h0;
    poly_wr = 1'b1;
    tick();
    poly_wr = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_vec("poly_msb_only", gen_q, 32'h0000_0100);
    poly_in = 32'h8020_0003;
    poly_wr = 1'b1;
    tick();
    poly_wr = 1'b0;

    // Lock again, then asynchronous reset without a clock edge
    enable = 1'b1;
    repeat (30) tick();
    check_vec("final_lock", chk_locked, 1'b1);
    reset = 1'b1;
    #2;
    check_vec("async_locked", chk_locked, 1'b0);
    check_vec("async_gen_q", gen_q, 32'h1);
    check_vec("async_errcnt", chk_errcnt, 4'h0);
    check_vec("async_gen_valid", gen_valid, 1'b0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
